// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with an RX byte queue popped by Wishbone reads.
// Optional sticky frame_err/overrun flags are enabled by defining UART_RX_ERR_EN.
module wb_uart_rx #(
  parameter int BUFFER          = 32,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rstz,
  input  logic                       rx,
  input  logic [PRESCALER_WIDTH-1:0] prescaler,
  input  logic                       clear,
  output logic [$clog2(BUFFER):0]    size,
  output logic [7:0]                 dat_o,
  input  logic                       we_i,
  input  logic                       stb_i,
  output logic                       ack_o
`ifdef UART_RX_ERR_EN
  ,
  output logic                       frame_err,
  output logic                       overrun
`endif
);

  localparam int AW = $clog2(BUFFER);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUFFER);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                     state_r, state_nx_s;
  logic                       rx_meta_r, rx_sync_r, rx_prev_r;
  logic [PRESCALER_WIDTH-1:0] cnt_r, presc_r;
  logic [2:0]                 bit_idx_r;
  logic [7:0]                 shift_r;
  logic                       mid_s, start_s, shift_s, push_s, ferr_s;
  logic [7:0]                 mem_r [BUFFER];
  logic [AW-1:0]              wr_ptr_r, rd_ptr_r;
  logic [AW:0]                count_r;
  logic                       full_s, empty_s, push_ok_s, pop_s, rd_s;
  logic                       ack_r;
  logic [7:0]                 dat_r;

  assign mid_s     = (cnt_r == (presc_r >> 1));
  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign push_ok_s = push_s & ~full_s;
  assign rd_s      = stb_i & ~we_i & ~ack_r;
  assign pop_s     = rd_s & ~empty_s;
  assign size      = count_r;
  assign dat_o     = dat_r;
  assign ack_o     = stb_i & ack_r;

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Receiver next-state and per-cycle strobes
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    shift_s    = 1'b0;
    push_s     = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r && rx_prev_r) begin
          state_nx_s = START;
          start_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (mid_s) begin
          if (rx_sync_r) state_nx_s = IDLE;
          else           state_nx_s = DATA;
        end else begin
          state_nx_s = START;
        end
      end
      DATA: begin
        if (mid_s) begin
          shift_s = 1'b1;
          if (bit_idx_r == 3'd7) state_nx_s = STOP;
          else                   state_nx_s = DATA;
        end else begin
          state_nx_s = DATA;
        end
      end
      STOP: begin
        // Deciding at mid-stop leaves half a bit of slack for a back-to-back start edge
        if (mid_s) begin
          if (rx_sync_r) begin
            push_s     = 1'b1;
            state_nx_s = IDLE;
          end else begin
            ferr_s     = 1'b1;
            state_nx_s = BREAK;
          end
        end else begin
          state_nx_s = STOP;
        end
      end
      BREAK: begin
        if (rx_sync_r) state_nx_s = IDLE;
        else           state_nx_s = BREAK;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Baud counter, latched prescaler, bit index and shift register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      cnt_r     <= {PRESCALER_WIDTH{1'b0}};
      presc_r   <= {PRESCALER_WIDTH{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (start_s) begin
        cnt_r   <= {PRESCALER_WIDTH{1'b0}};
        presc_r <= prescaler;
      end else if (state_r == START || state_r == DATA || state_r == STOP) begin
        if (cnt_r == presc_r) begin
          cnt_r   <= {PRESCALER_WIDTH{1'b0}};
          presc_r <= prescaler;
        end else begin
          cnt_r <= cnt_r + PRESCALER_WIDTH'(1);
        end
      end else begin
        cnt_r <= {PRESCALER_WIDTH{1'b0}};
      end
      if (start_s) begin
        bit_idx_r <= 3'd0;
      end else if (shift_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
        shift_r   <= {rx_sync_r, shift_r[7:1]};
      end
    end
  end

  // Queue storage; data written only for accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear) mem_r[wr_ptr_r] <= {rx_sync_r ? shift_r : shift_r};
  end

  // Queue pointers and occupancy; clear overrides push and pop
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Wishbone ack and read data; ack is dropped the cycle after it rises
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ack_r <= 1'b0;
      dat_r <= 8'h00;
    end else begin
      ack_r <= stb_i & ~ack_r;
      if (rd_s) dat_r <= empty_s ? 8'h00 : mem_r[rd_ptr_r];
    end
  end

`ifdef UART_RX_ERR_EN
  // Sticky error flags; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_s)           frame_err <= 1'b1;
      if (push_s && full_s) overrun   <= 1'b1;
    end
  end
`endif

endmodule
